restoring_divider_8: RTL and testbench
======================================

RESTORING_DIVIDER_8 -- requirements
Module: restoring_divider_8

Interface
REQ-001 SHALL have port Clk, input, 1 bit: system clock; all state updates on posedge.
REQ-002 SHALL have port Reset, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port Run, input, 1 bit: active-low pushbutton that starts one division.
REQ-004 SHALL have port LoadB, input, 1 bit: active-low pushbutton that loads the divisor.
REQ-005 SHALL have port SW, input, 8 bits: dividend (on start) or divisor (on LoadB).
REQ-006 SHALL have port Q, output, 8 bits: registered quotient.
REQ-007 SHALL have port R, output, 8 bits: registered remainder.
REQ-008 SHALL have port DivZero, output, 1 bit: registered flag, last operation had divisor 0.
REQ-009 SHALL have port Busy, output, 1 bit: registered, high while computing.
REQ-010 SHALL have ports Qhex0, Qhex1, Rhex0, Rhex1, output, 7 bits each: registered seven-segment codes for Q[3:0], Q[7:4], R[3:0], R[7:4].

Function
REQ-011 SHALL hold an 8-bit divisor register B; B <= SW when LoadB==0 and state==IDLE; LoadB SHALL be ignored in CALC and DONE.
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 IDLE: when Run==0 is sampled at edge k, SHALL load work quotient <= SW, work remainder <= 0, count <= 0, state <= CALC, Busy <= 1.
REQ-014 CALC: each edge SHALL shift {rem,quo} left 1; 9-bit trial = shifted rem - B; if trial non-negative, rem <= trial[7:0] and quo[0] <= 1, else quo[0] <= 0; count SHALL increment.
REQ-015 CALC SHALL perform exactly 8 iterations, at edges k+1..k+8; at edge k+8 SHALL write Q, R from the final work values, DivZero <= 0, Busy <= 0, and state <= DONE.
REQ-016 Q, R, DivZero SHALL hold their previous values during CALC and change only on completion.
REQ-017 If B==0 at the start edge k, SHALL skip CALC: at edge k+1 Q <= 8'hFF, R <= dividend, DivZero <= 1, Busy <= 0, state <= DONE; Busy SHALL be high for exactly one cycle.
REQ-018 DONE: SHALL remain in DONE while Run==0 and return to IDLE on the first edge with Run==1; a held Run SHALL produce exactly one division.
REQ-019 SW changes during CALC SHALL NOT affect the result; B SHALL NOT change during CALC.
REQ-020 Hex outputs SHALL be registered one cycle after Q/R; encoding is active-low, bit order gfedcba, 0..F = 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
REQ-021 Arithmetic SHALL be unsigned; invariant for B!=0: dividend == Q*B + R with R < B.

Reset
REQ-022 Reset==0 at any edge SHALL force state IDLE, B=0, Q=0, R=0, DivZero=0, Busy=0, count=0, and work registers=0, overriding Run and LoadB.
REQ-023 Hex outputs SHALL reset to 7'h40 (digit 0) at the same edge.
REQ-024 Reset mid-CALC SHALL abort the operation with no partial result on Q/R; the next Run after release SHALL start a fresh division.

Verification
REQ-025 Reset, LoadB with SW=7, Run with SW=200 -> Busy high 8 cycles, then Q=0x1C, R=0x04, DivZero=0; Qhex1=0x79, Qhex0=0x46 one cycle later.
REQ-026 B=1, dividend 255 -> Q=0xFF, R=0x00; B=10, dividend 5 -> Q=0x00, R=0x05.
REQ-027 B=0, dividend 0x5A -> one cycle later Q=0xFF, R=0x5A, DivZero=1, Busy pulse 1 cycle.
REQ-028 Run held low for 50 cycles -> exactly one completion; the DONE->IDLE transition occurs only after release, and a second press starts a new division.
REQ-029 LoadB pressed with SW=3 during CALC (B=7, dividend=200) -> result still Q=0x1C, R=0x04, and B remains 7.
REQ-030 Reset asserted at iteration 4 -> all outputs 0, hex 0x40, state IDLE; subsequent 100/9 -> Q=0x0B, R=0x01.

Source files
------------

// File: rtl/restoring_divider_8.sv
// restoring_divider_8: 8-bit unsigned restoring divider with pushbutton
// controls (Run starts a division, LoadB captures the divisor), registered
// quotient/remainder and registered seven-segment displays of both.
module restoring_divider_8 (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Run,
   input  logic       LoadB,
   input  logic [7:0] SW,
   output logic [7:0] Q,
   output logic [7:0] R,
   output logic       DivZero,
   output logic       Busy,
   output logic [6:0] Qhex0,
   output logic [6:0] Qhex1,
   output logic [6:0] Rhex0,
   output logic [6:0] Rhex1
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t     state, state_next;
   logic [7:0] b_reg;
   logic [7:0] quo, rem;
   logic [2:0] count;

   logic       start, step, last, dz_hit;
   logic [8:0] shifted;
   logic       fits;
   logic [7:0] quo_next, rem_next;

   // Active-low segment code, bit order gfedcba.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: seg7 = 7'h40;
         4'h1: seg7 = 7'h79;
         4'h2: seg7 = 7'h24;
         4'h3: seg7 = 7'h30;
         4'h4: seg7 = 7'h19;
         4'h5: seg7 = 7'h12;
         4'h6: seg7 = 7'h02;
         4'h7: seg7 = 7'h78;
         4'h8: seg7 = 7'h00;
         4'h9: seg7 = 7'h10;
         4'hA: seg7 = 7'h08;
         4'hB: seg7 = 7'h03;
         4'hC: seg7 = 7'h46;
         4'hD: seg7 = 7'h21;
         4'hE: seg7 = 7'h06;
         default: seg7 = 7'h0E;
      endcase
   endfunction

   // One restoring step. The shifted remainder needs 9 bits (rem < B can be
   // up to 254); when it fits, the true difference is < B, so an 8-bit
   // subtraction gives the exact new remainder.
   always_comb begin
      shifted  = {rem, quo[7]};
      fits     = (shifted >= {1'b0, b_reg});
      quo_next = {quo[6:0], fits};
      rem_next = fits ? (shifted[7:0] - b_reg) : shifted[7:0];
   end

   // State register.
   always_ff @(posedge Clk) begin
      if (!Reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic; DONE waits for Run release so a held button divides once.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (!Run) state_next = CALC;
         CALC:    if (b_reg == 8'd0 || count == 3'd7) state_next = DONE;
         DONE:    if (Run) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Control decode; a zero divisor is caught on the first CALC cycle.
   always_comb begin
      start  = (state == IDLE) && !Run;
      step   = (state == CALC) && (b_reg != 8'd0);
      dz_hit = (state == CALC) && (b_reg == 8'd0);
      last   = step && (count == 3'd7);
   end

   // Datapath: divisor capture, work registers and result registers.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         b_reg   <= '0;
         quo     <= '0;
         rem     <= '0;
         count   <= '0;
         Q       <= '0;
         R       <= '0;
         DivZero <= 1'b0;
         Busy    <= 1'b0;
      end else begin
         if (state == IDLE && !LoadB) b_reg <= SW;
         if (start) begin
            quo   <= SW;
            rem   <= '0;
            count <= '0;
            Busy  <= 1'b1;
         end else if (dz_hit) begin
            Q       <= 8'hFF;
            R       <= quo;      // dividend untouched, no iteration ran
            DivZero <= 1'b1;
            Busy    <= 1'b0;
         end else if (step) begin
            quo   <= quo_next;
            rem   <= rem_next;
            count <= count + 3'd1;
            if (last) begin
               Q       <= quo_next;
               R       <= rem_next;
               DivZero <= 1'b0;
               Busy    <= 1'b0;
            end
         end
      end
   end

   // Display registers trail Q/R by one cycle.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         Qhex0 <= 7'h40;
         Qhex1 <= 7'h40;
         Rhex0 <= 7'h40;
         Rhex1 <= 7'h40;
      end else begin
         Qhex0 <= seg7(Q[3:0]);
         Qhex1 <= seg7(Q[7:4]);
         Rhex0 <= seg7(R[3:0]);
         Rhex1 <= seg7(R[7:4]);
      end
   end

endmodule

// File: tb/tb_restoring_divider_8.sv
// Testbench for restoring_divider_8: directed steps with a result scoreboard.
module tb_restoring_divider_8;

   logic       Clk = 1'b0;
   logic       Reset, Run, LoadB;
   logic [7:0] SW;
   logic [7:0] Q, R;
   logic       DivZero, Busy;
   logic [6:0] Qhex0, Qhex1, Rhex0, Rhex1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      int         busy;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] b_model = 8'd0;
   logic [6:0] seg_tb [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   restoring_divider_8 dut (
      .Clk(Clk), .Reset(Reset), .Run(Run), .LoadB(LoadB), .SW(SW),
      .Q(Q), .R(R), .DivZero(DivZero), .Busy(Busy),
      .Qhex0(Qhex0), .Qhex1(Qhex1), .Rhex0(Rhex0), .Rhex1(Rhex1)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [7:0] dvd);
      exp_t e;
      if (b_model == 8'd0) begin
         e.q = 8'hFF; e.r = dvd; e.dz = 1'b1; e.busy = 1;
      end else begin
         e.q = dvd / b_model; e.r = dvd % b_model; e.dz = 1'b0; e.busy = 8;
      end
      return e;
   endfunction

   task automatic load_b(input logic [7:0] v);
      @(negedge Clk); SW = v; LoadB = 1'b0;
      @(negedge Clk); LoadB = 1'b1;
      b_model = v;
   endtask

   // Pop the oldest expectation and compare the completed result, then the
   // display one cycle later.
   task automatic check_result(input string tag, input int n);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 16'd1, 16'd0);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_busy_cycles"}, 16'(n), 16'(e.busy));
      chk({tag, "_Q"}, 16'(Q), 16'(e.q));
      chk({tag, "_R"}, 16'(R), 16'(e.r));
      chk({tag, "_DivZero"}, 16'(DivZero), 16'(e.dz));
      @(negedge Clk);
      chk({tag, "_Qhex0"}, 16'(Qhex0), 16'(seg_tb[e.q[3:0]]));
      chk({tag, "_Qhex1"}, 16'(Qhex1), 16'(seg_tb[e.q[7:4]]));
      chk({tag, "_Rhex0"}, 16'(Rhex0), 16'(seg_tb[e.r[3:0]]));
      chk({tag, "_Rhex1"}, 16'(Rhex1), 16'(seg_tb[e.r[7:4]]));
   endtask

   // One division with a one-cycle Run press; optional LoadB/SW noise while busy.
   task automatic divide(input string tag, input logic [7:0] dvd, input bit noise);
      int n;
      logic [7:0] q0, r0;
      sb.push_back(model(dvd));
      q0 = Q; r0 = R;
      @(negedge Clk); SW = dvd; Run = 1'b0;
      @(negedge Clk); Run = 1'b1;
      n = 0;
      while (Busy === 1'b1 && n < 20) begin
         n++;
         if (n == 4) begin
            chk({tag, "_Q_hold"}, 16'(Q), 16'(q0));
            chk({tag, "_R_hold"}, 16'(R), 16'(r0));
         end
         if (noise) begin SW = 8'd3 + 8'(n); LoadB = 1'b0; end
         @(negedge Clk);
      end
      LoadB = 1'b1;
      check_result(tag, n);
   endtask

   initial begin
      int n, rises;
      logic pb;
      Reset = 1'b0; Run = 1'b1; LoadB = 1'b1; SW = 8'h00;
      repeat (3) @(negedge Clk);
      chk("rst_Q", 16'(Q), 16'h0);
      chk("rst_R", 16'(R), 16'h0);
      chk("rst_DivZero", 16'(DivZero), 16'h0);
      chk("rst_Busy", 16'(Busy), 16'h0);
      chk("rst_Qhex0", 16'(Qhex0), 16'h40);
      chk("rst_Rhex1", 16'(Rhex1), 16'h40);
      Reset = 1'b1;

      // Basic 200/7, edge values, divide-by-zero.
      load_b(8'd7);
      divide("d200_7", 8'd200, 1'b0);
      load_b(8'd1);
      divide("d255_1", 8'd255, 1'b0);
      load_b(8'd10);
      divide("d5_10", 8'd5, 1'b0);
      load_b(8'd0);
      divide("d5A_0", 8'h5A, 1'b0);
      load_b(8'd255);
      divide("d254_255", 8'd254, 1'b0);
      load_b(8'd128);
      divide("d255_128", 8'd255, 1'b0);

      // Random operands.
      for (int i = 0; i < 6; i++) begin
         load_b(8'($urandom_range(1, 255)));
         divide("rand", 8'($urandom_range(0, 255)), 1'b0);
      end

      // LoadB and SW activity during CALC are ignored.
      load_b(8'd7);
      divide("noise200_7", 8'd200, 1'b1);
      divide("after_noise100_7", 8'd100, 1'b0);

      // Held Run: exactly one division; LoadB in DONE ignored.
      sb.push_back(model(8'd100));
      @(negedge Clk); SW = 8'd100; Run = 1'b0;
      rises = 0; pb = 1'b0; n = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge Clk);
         if (Busy === 1'b1) n++;
         if (Busy === 1'b1 && pb === 1'b0) rises++;
         pb = Busy;
         if (c == 30) begin SW = 8'd3; LoadB = 1'b0; end
         if (c == 31) LoadB = 1'b1;
      end
      chk("held_one_start", 16'(rises), 16'd1);
      chk("held_Busy_low", 16'(Busy), 16'd0);
      check_result("held100_7", n);
      Run = 1'b1;
      @(negedge Clk);
      divide("second_press200_7", 8'd200, 1'b0);

      // Reset in the middle of CALC.
      @(negedge Clk); SW = 8'd200; Run = 1'b0;
      @(negedge Clk); Run = 1'b1;
      repeat (3) @(negedge Clk);
      chk("mid_Busy", 16'(Busy), 16'd1);
      Reset = 1'b0;
      @(negedge Clk);
      Reset = 1'b1;
      b_model = 8'd0;
      chk("abort_Q", 16'(Q), 16'h0);
      chk("abort_R", 16'(R), 16'h0);
      chk("abort_DivZero", 16'(DivZero), 16'h0);
      chk("abort_Busy", 16'(Busy), 16'h0);
      chk("abort_Qhex0", 16'(Qhex0), 16'h40);
      chk("abort_Qhex1", 16'(Qhex1), 16'h40);
      chk("abort_Rhex0", 16'(Rhex0), 16'h40);
      chk("abort_Rhex1", 16'(Rhex1), 16'h40);
      // Divisor was cleared by reset, so an immediate run is a divide-by-zero.
      divide("post_rst_dz", 8'h5A, 1'b0);
      load_b(8'd9);
      divide("d100_9", 8'd100, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
